// File: rtl/motor_pkg.sv
// Motor mode bus encoding and classification helpers.
// Shared by the sequencer, the motor block and the decision logic.
package motor_pkg;

  localparam logic [2:0] STOP       = 3'b000;
  localparam logic [2:0] STRAIGHT_1 = 3'b001;
  localparam logic [2:0] STRAIGHT_2 = 3'b010;
  localparam logic [2:0] STRAIGHT_3 = 3'b011;
  localparam logic [2:0] LEFT_1     = 3'b100;
  localparam logic [2:0] LEFT_2     = 3'b101;
  localparam logic [2:0] RIGHT_1    = 3'b110;
  localparam logic [2:0] RIGHT_2    = 3'b111;

  typedef enum logic [1:0] {
    ST_STEADY,
    ST_RAMP,
    ST_DEAD,
    ST_ESTOP
  } seq_state_t;

  typedef struct packed {
    logic [2:0] mode;
    seq_state_t state;
  } step_t;

  function automatic logic is_left(
    input logic [2:0] m
  );
    return m[2:1] == 2'b10;
  endfunction

  function automatic logic is_right(
    input logic [2:0] m
  );
    return m[2:1] == 2'b11;
  endfunction

  function automatic logic is_straight(
    input logic [2:0] m
  );
    return (m != STOP) && !m[2];
  endfunction

  // Settled-state decision for a new target
  // against the currently applied mode.
  function automatic step_t steady_rule(
    input logic [2:0] cur,
    input logic [2:0] tgt
  );
    step_t r;
    r.mode  = cur;
    r.state = ST_STEADY;
    if (tgt == cur) begin
      r.mode = cur;
    end else if ((is_left(cur) && is_right(tgt)) ||
                 (is_right(cur) && is_left(tgt))) begin
      r.mode  = STOP;
      r.state = ST_DEAD;
    end else if (is_straight(tgt) && is_straight(cur) &&
                 (tgt > cur)) begin
      r.mode  = cur + 3'd1;
      r.state = (cur + 3'd1 == tgt) ? ST_STEADY : ST_RAMP;
    end else if (is_straight(tgt) && !is_straight(cur)) begin
      r.mode  = STRAIGHT_1;
      r.state = (tgt == STRAIGHT_1) ? ST_STEADY : ST_RAMP;
    end else begin
      r.mode = tgt;
    end
    return r;
  endfunction

endpackage

// File: rtl/motor_mode_sequencer_dwell_timer.sv
// Dwell counter shared by speed ramping and turn dead-time.
// Clears on load or on reaching limit; never wraps.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt >= limit);

  // Count up, restart on load or when the dwell completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_mode_sequencer.sv
// Applies requested motor modes safely: speed ramp,
// turn-reversal dead-time and emergency stop.
module motor_mode_sequencer
  import motor_pkg::*;
#(
  parameter int RAMP_CYCLES = 25_000_000,
  parameter int DEAD_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  input  logic       estop,
  output logic [2:0] mode,
  output logic       settled,
  output logic       estop_act
);

  localparam int MAX_CYC =
    (RAMP_CYCLES > DEAD_CYCLES) ? RAMP_CYCLES : DEAD_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RAMP_LIM =
    CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM =
    CNT_W'(DEAD_CYCLES - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [2:0]       target_q;
  logic [2:0]       target_d;
  logic [2:0]       mode_d;
  logic             settled_d;
  logic             estop_act_d;
  logic             load;
  logic             expire;
  logic [CNT_W-1:0] limit;
  logic [2:0]       tgt_eff;
  step_t            step;

  assign limit   = (state_q == ST_DEAD) ? DEAD_LIM : RAMP_LIM;
  assign tgt_eff = req_valid ? req_mode : target_q;
  assign step    = steady_rule(mode, req_mode);

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .limit  (limit),
    .expire (expire)
  );

  // State, target and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STEADY;
      target_q  <= STOP;
      mode      <= STOP;
      settled   <= 1'b1;
      estop_act <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      mode      <= mode_d;
      settled   <= settled_d;
      estop_act <= estop_act_d;
    end
  end

  // Next state, next target and next applied mode
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode;
    load     = 1'b0;
    if (estop) begin
      state_d  = ST_ESTOP;
      target_d = STOP;
      mode_d   = STOP;
    end else begin
      unique case (state_q)
        ST_STEADY: begin
          if (req_valid) begin
            target_d = req_mode;
            mode_d   = step.mode;
            state_d  = step.state;
            load     = 1'b1;
          end
        end
        ST_RAMP: begin
          if (req_valid) begin
            target_d = req_mode;
            mode_d   = step.mode;
            state_d  = step.state;
            load     = 1'b1;
          end else if (expire) begin
            mode_d  = mode + 3'd1;
            state_d = (mode + 3'd1 == target_q) ?
                      ST_STEADY : ST_RAMP;
          end
        end
        ST_DEAD: begin
          target_d = tgt_eff;
          if (req_valid && (req_mode == STOP)) begin
            state_d = ST_STEADY;
          end else if (expire) begin
            if (is_straight(tgt_eff)) begin
              mode_d  = STRAIGHT_1;
              state_d = (tgt_eff == STRAIGHT_1) ?
                        ST_STEADY : ST_RAMP;
              load    = 1'b1;
            end else begin
              mode_d  = tgt_eff;
              state_d = ST_STEADY;
            end
          end
        end
        ST_ESTOP: begin
          state_d  = ST_STEADY;
          target_d = STOP;
          mode_d   = STOP;
        end
      endcase
    end
  end

  // Status flags derived from the upcoming state
  always_comb begin
    settled_d   = (state_d == ST_STEADY) && (mode_d == target_d);
    estop_act_d = (state_d == ST_ESTOP);
  end

endmodule
